// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: ALU and LSU results are queued in per-source FIFOs and
// broadcast one per cycle on a registered CDB under round-robin arbitration.
module cdb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ROB_ID_W   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rdy,
    input  logic                flush,
    input  logic                alu_valid,
    input  logic [ROB_ID_W-1:0] alu_rob_id,
    input  logic [DATA_W-1:0]   alu_result,
    output logic                alu_ready,
    input  logic                lsu_valid,
    input  logic [ROB_ID_W-1:0] lsu_rob_id,
    input  logic [DATA_W-1:0]   lsu_result,
    output logic                lsu_ready,
    output logic                cdb_valid,
    output logic [ROB_ID_W-1:0] cdb_rob_id,
    output logic [DATA_W-1:0]   cdb_result,
    output logic                cdb_src
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = ROB_ID_W + DATA_W;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } src_e;

    logic [ENT_W-1:0]    r_alu_mem [FIFO_DEPTH];
    logic [ENT_W-1:0]    r_lsu_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_alu_wr;
    logic [PTR_W-1:0]    r_alu_rd;
    logic [PTR_W-1:0]    r_lsu_wr;
    logic [PTR_W-1:0]    r_lsu_rd;
    logic [CNT_W-1:0]    r_alu_cnt;
    logic [CNT_W-1:0]    r_lsu_cnt;
    src_e                r_last;
    logic                r_cdb_valid;
    logic [ROB_ID_W-1:0] r_cdb_rob_id;
    logic [DATA_W-1:0]   r_cdb_result;
    src_e                r_cdb_src;

    logic                w_alu_ready;
    logic                w_lsu_ready;
    logic                w_alu_push;
    logic                w_lsu_push;
    logic                w_alu_pop;
    logic                w_lsu_pop;
    logic                w_alu_nempty;
    logic                w_lsu_nempty;
    logic                w_grant;
    src_e                w_gnt_src;
    logic [ENT_W-1:0]    w_head;

    always_comb begin
        w_alu_ready  = rdy && (r_alu_cnt < DEPTH_C);
        w_lsu_ready  = rdy && (r_lsu_cnt < DEPTH_C);
        w_alu_push   = alu_valid && w_alu_ready && !flush;
        w_lsu_push   = lsu_valid && w_lsu_ready && !flush;
        w_alu_nempty = (r_alu_cnt != '0);
        w_lsu_nempty = (r_lsu_cnt != '0);

        // Arbitration uses pre-edge counts, so a result never bypasses its FIFO.
        w_gnt_src = SRC_ALU;
        if (w_alu_nempty && w_lsu_nempty) begin
            w_gnt_src = (r_last == SRC_ALU) ? SRC_LSU : SRC_ALU;
        end else if (w_lsu_nempty) begin
            w_gnt_src = SRC_LSU;
        end
        w_grant   = rdy && !flush && (w_alu_nempty || w_lsu_nempty);
        w_alu_pop = w_grant && (w_gnt_src == SRC_ALU);
        w_lsu_pop = w_grant && (w_gnt_src == SRC_LSU);
        w_head    = (w_gnt_src == SRC_LSU) ? r_lsu_mem[r_lsu_rd] : r_alu_mem[r_alu_rd];
    end

    always_ff @(posedge clk) begin
        if (w_alu_push) begin
            r_alu_mem[r_alu_wr] <= {alu_rob_id, alu_result};
        end
        if (w_lsu_push) begin
            r_lsu_mem[r_lsu_wr] <= {lsu_rob_id, lsu_result};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_cnt <= '0;
            r_alu_wr  <= '0;
            r_alu_rd  <= '0;
        end else if (rdy) begin
            if (flush) begin
                r_alu_cnt <= '0;
                r_alu_wr  <= '0;
                r_alu_rd  <= '0;
            end else begin
                if (w_alu_push) r_alu_wr <= r_alu_wr + PTR_ONE;
                if (w_alu_pop)  r_alu_rd <= r_alu_rd + PTR_ONE;
                if (w_alu_push && !w_alu_pop) begin
                    r_alu_cnt <= r_alu_cnt + CNT_ONE;
                end else if (!w_alu_push && w_alu_pop) begin
                    r_alu_cnt <= r_alu_cnt - CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lsu_cnt <= '0;
            r_lsu_wr  <= '0;
            r_lsu_rd  <= '0;
        end else if (rdy) begin
            if (flush) begin
                r_lsu_cnt <= '0;
                r_lsu_wr  <= '0;
                r_lsu_rd  <= '0;
            end else begin
                if (w_lsu_push) r_lsu_wr <= r_lsu_wr + PTR_ONE;
                if (w_lsu_pop)  r_lsu_rd <= r_lsu_rd + PTR_ONE;
                if (w_lsu_push && !w_lsu_pop) begin
                    r_lsu_cnt <= r_lsu_cnt + CNT_ONE;
                end else if (!w_lsu_push && w_lsu_pop) begin
                    r_lsu_cnt <= r_lsu_cnt - CNT_ONE;
                end
            end
        end
    end

    // Idle cycles only clear cdb_valid; tag, value and source keep their last broadcast.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cdb_valid  <= 1'b0;
            r_cdb_rob_id <= '0;
            r_cdb_result <= '0;
            r_cdb_src    <= SRC_ALU;
            r_last       <= SRC_LSU;
        end else if (rdy) begin
            if (flush) begin
                r_cdb_valid <= 1'b0;
                r_last      <= SRC_LSU;
            end else if (w_grant) begin
                r_cdb_valid  <= 1'b1;
                r_cdb_rob_id <= w_head[ENT_W-1:DATA_W];
                r_cdb_result <= w_head[DATA_W-1:0];
                r_cdb_src    <= w_gnt_src;
                r_last       <= w_gnt_src;
            end else begin
                r_cdb_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        alu_ready  = w_alu_ready;
        lsu_ready  = w_lsu_ready;
        cdb_valid  = r_cdb_valid;
        cdb_rob_id = r_cdb_rob_id;
        cdb_result = r_cdb_result;
        cdb_src    = r_cdb_src;
    end

endmodule
